// File: rtl/rtc_bus_ctrl.sv
// Sequencer turning one micro port access into a two-phase RTC multiplexed-bus cycle:
// an address write phase followed by a data write or read phase.
module rtc_bus_ctrl #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 8,
    parameter int unsigned T_HOLD  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       actRTC,
    input  logic       writestrobe,
    input  logic       read_strobe,
    input  logic [7:0] dir,
    input  logic [7:0] out_port,
    output logic [7:0] in_portRTC,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam logic [7:0] SetupCnt = 8'(T_SETUP);
    localparam logic [7:0] PulseCnt = 8'(T_PULSE);
    localparam logic [7:0] HoldCnt  = 8'(T_HOLD);

    typedef enum logic [3:0] {
        StIdle,
        StASu,
        StAStb,
        StAHld,
        StGap,
        StDSu,
        StDStb,
        StDHld,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       req, req_q;
    logic       start, accept, expire;
    logic       write_q;
    logic [7:0] addr_q, wdata_q;

    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       ad_sel_q, ad_sel_d;
    logic       ad_oe_q, ad_oe_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       busy_q, done_q, overrun_q;
    logic [7:0] rdata_q;
    logic       capture;

    function automatic logic [7:0] state_len(input state_e s);
        case (s)
            StASu, StDSu:         state_len = SetupCnt;
            StAStb, StDStb:       state_len = PulseCnt;
            StAHld, StGap, StDHld: state_len = HoldCnt;
            StDone:               state_len = 8'd1;
            default:              state_len = 8'd0;
        endcase
    endfunction

    assign req    = actRTC & (writestrobe | read_strobe);
    assign start  = req & ~req_q;
    assign accept = start && (state_q == StIdle);
    assign expire = (cnt_q <= 8'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StASu;
            StASu:   if (expire) state_d = StAStb;
            StAStb:  if (expire) state_d = StAHld;
            StAHld:  if (expire) state_d = StGap;
            StGap:   if (expire) state_d = StDSu;
            StDSu:   if (expire) state_d = StDStb;
            StDStb:  if (expire) state_d = StDHld;
            StDHld:  if (expire) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = state_len(state_d);
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Bus outputs are decoded from the current state and registered, so they trail it by a cycle.
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_sel_d = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;
        case (state_q)
            StASu, StAStb, StAHld: begin
                cs_n_d   = 1'b0;
                ad_sel_d = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
                wr_n_d   = (state_q != StAStb);
            end
            StDSu, StDStb, StDHld: begin
                cs_n_d = 1'b0;
                if (write_q) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_q;
                    wr_n_d   = (state_q != StDStb);
                end else begin
                    rd_n_d = (state_q != StDStb);
                end
            end
            default: ;
        endcase
    end

    // Sample on the last low cycle of rd_n, just before it is released.
    assign capture = ~rd_n_q & rd_n_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            req_q     <= 1'b1;
            write_q   <= 1'b0;
            addr_q    <= 8'd0;
            wdata_q   <= 8'd0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_sel_q  <= 1'b1;
            ad_oe_q   <= 1'b0;
            ad_out_q  <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            rdata_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            ad_sel_q <= ad_sel_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            busy_q   <= (state_q != StIdle);
            done_q   <= (state_q == StDone);
            if (accept) begin
                write_q <= writestrobe;
                addr_q  <= dir;
                wdata_q <= out_port;
            end
            if (start && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            if (capture) begin
                rdata_q <= ad_in;
            end
        end
    end

    assign in_portRTC = rdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;
    assign cs_n       = cs_n_q;
    assign rd_n       = rd_n_q;
    assign wr_n       = wr_n_q;
    assign ad_sel     = ad_sel_q;
    assign ad_out     = ad_out_q;
    assign ad_oe      = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: records bus outputs cycle by cycle and compares
// strobe counts, phase timing and captured data against hand-computed values.
module tb_rtc_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       actRTC, writestrobe, read_strobe;
    logic [7:0] dir, out_port, in_portRTC, ad_out, ad_in, rd_model;
    logic       busy, done, overrun, cs_n, rd_n, wr_n, ad_sel, ad_oe;

    int errors = 0;
    int checks = 0;

    rtc_bus_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .actRTC     (actRTC),
        .writestrobe(writestrobe),
        .read_strobe(read_strobe),
        .dir        (dir),
        .out_port   (out_port),
        .in_portRTC (in_portRTC),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .ad_sel     (ad_sel),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .ad_in      (ad_in)
    );

    always #5 clk = ~clk;

    // RTC chip model: drives the read byte only while rd_n is low.
    assign ad_in = rd_n ? 8'hA5 : rd_model;

    logic       s_cs[64], s_wr[64], s_rd[64], s_sel[64], s_oe[64], s_dn[64], s_bz[64], s_ov[64];
    logic [7:0] s_ao[64], s_in[64];

    int wr_a, wr_d, rd_lo, oe_d, ao_a_bad, ao_d_bad, first_cs, first_done, n_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample i is taken 1ns after the (i+1)-th rising edge following the request.
    task automatic run(input logic we, input logic re, input logic [7:0] d, input logic [7:0] data,
                       input int n, input int at2, input logic we2, input logic re2,
                       input logic [7:0] d2, input logic [7:0] data2);
        actRTC      = 1'b1;
        writestrobe = we;
        read_strobe = re;
        dir         = d;
        out_port    = data;
        for (int i = 0; i < n; i++) begin
            tick();
            s_cs[i] = cs_n;  s_wr[i] = wr_n;   s_rd[i] = rd_n; s_sel[i] = ad_sel;
            s_oe[i] = ad_oe; s_dn[i] = done;   s_bz[i] = busy; s_ov[i]  = overrun;
            s_ao[i] = ad_out; s_in[i] = in_portRTC;
            if (i == at2) begin
                actRTC = 1'b1; writestrobe = we2; read_strobe = re2; dir = d2; out_port = data2;
            end else if (i == 0 || i == at2 + 1) begin
                actRTC = 1'b0; writestrobe = 1'b0; read_strobe = 1'b0;
                dir = 8'hFF; out_port = 8'hEE;
            end
        end
    endtask

    task automatic summarize(input int lo, input int hi, input logic [7:0] ea,
                             input logic [7:0] ed);
        wr_a = 0; wr_d = 0; rd_lo = 0; oe_d = 0; ao_a_bad = 0; ao_d_bad = 0;
        first_cs = -1; first_done = -1; n_done = 0;
        for (int i = lo; i <= hi; i++) begin
            if (!s_cs[i] && first_cs < 0) first_cs = i;
            if (s_dn[i]) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
            if (!s_wr[i]) begin
                if (!s_sel[i]) wr_a++;
                else wr_d++;
            end
            if (!s_rd[i]) rd_lo++;
            if (!s_cs[i] && !s_sel[i] && s_ao[i] != ea) ao_a_bad++;
            if (!s_cs[i] && s_sel[i] && s_oe[i]) begin
                oe_d++;
                if (s_ao[i] != ed) ao_d_bad++;
            end
        end
    endtask

    initial begin
        reset = 1'b0; actRTC = 1'b0; writestrobe = 1'b0; read_strobe = 1'b0;
        dir = 8'h00; out_port = 8'h00; rd_model = 8'h00;
        #12;
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_wr_rd_n", {wr_n, rd_n}, 2'b11);
        check("rst_sel_oe", {ad_sel, ad_oe}, 2'b10);
        check("rst_status", {busy, done, overrun}, 3'b000);
        check("rst_data", {in_portRTC, ad_out}, 16'h0000);
        reset = 1'b1;
        repeat (3) tick();

        // Write 0x45 to register 0x21
        run(1'b1, 1'b0, 8'h21, 8'h45, 30, -1, 1'b0, 1'b0, 8'h00, 8'h00);
        summarize(0, 29, 8'h21, 8'h45);
        check("wr_first_cs", first_cs, 1);
        check("wr_addr_pulse", wr_a, 8);
        check("wr_data_pulse", wr_d, 8);
        check("wr_no_rd", rd_lo, 0);
        check("wr_addr_val", ao_a_bad, 0);
        check("wr_data_val", ao_d_bad, 0);
        check("wr_data_oe", oe_d, 12);
        check("wr_gap", {s_cs[12], s_cs[13], s_cs[14], s_cs[15]}, 4'b0110);
        check("wr_done_at", first_done, 27);
        check("wr_done_cnt", n_done, 1);
        check("wr_busy_end", {s_bz[1], s_bz[27], s_bz[28]}, 3'b110);
        check("wr_inport", s_in[29], 8'h00);

        // Read register 0x22, chip returns 0x59
        rd_model = 8'h59;
        run(1'b0, 1'b1, 8'h22, 8'h00, 30, -1, 1'b0, 1'b0, 8'h00, 8'h00);
        summarize(0, 29, 8'h22, 8'h00);
        check("rd_rd_pulse", rd_lo, 8);
        check("rd_rd_window", {s_rd[16], s_rd[17], s_rd[24], s_rd[25]}, 4'b1001);
        check("rd_addr_pulse", wr_a, 8);
        check("rd_no_data_wr", wr_d, 0);
        check("rd_data_oe", oe_d, 0);
        check("rd_inport_pre", s_in[24], 8'h00);
        check("rd_inport", s_in[25], 8'h59);
        check("rd_done_at", first_done, 27);
        check("rd_busy_end", {s_bz[27], s_bz[28]}, 2'b10);

        // Both strobes: write wins
        run(1'b1, 1'b1, 8'h23, 8'h67, 30, -1, 1'b0, 1'b0, 8'h00, 8'h00);
        summarize(0, 29, 8'h23, 8'h67);
        check("both_no_rd", rd_lo, 0);
        check("both_data_wr", wr_d, 8);
        check("both_data_val", ao_d_bad, 0);
        check("both_inport", s_in[29], 8'h59);

        // Back-to-back: write, then a read whose request edge is 28 cycles later
        rd_model = 8'h3C;
        run(1'b1, 1'b0, 8'h10, 8'h11, 60, 27, 1'b0, 1'b1, 8'h12, 8'h00);
        summarize(0, 59, 8'h10, 8'h11);
        check("b2b_done_cnt", n_done, 2);
        check("b2b_overrun", s_ov[59], 1'b0);
        summarize(28, 59, 8'h12, 8'h00);
        check("b2b_second_cs", first_cs, 29);
        check("b2b_second_addr", ao_a_bad, 0);
        check("b2b_second_rd", rd_lo, 8);
        check("b2b_inport", s_in[59], 8'h3C);

        // Overrun: second request edge during a write is dropped
        run(1'b1, 1'b0, 8'h31, 8'h32, 32, 10, 1'b1, 1'b0, 8'h77, 8'h78);
        summarize(0, 31, 8'h31, 8'h32);
        check("ovr_before", s_ov[10], 1'b0);
        check("ovr_set", s_ov[11], 1'b1);
        check("ovr_sticky", s_ov[31], 1'b1);
        check("ovr_done_cnt", n_done, 1);
        check("ovr_data_val", ao_d_bad, 0);
        check("ovr_no_restart", {s_bz[28], s_bz[31]}, 2'b00);

        // Reset during the address strobe with the request held high
        actRTC = 1'b1; writestrobe = 1'b1; dir = 8'h41; out_port = 8'h42;
        repeat (6) tick();
        check("mid_pre_wr", {wr_n, busy}, 2'b01);
        reset = 1'b0;
        #1;
        check("mid_rst_bus", {wr_n, cs_n, ad_oe}, 3'b110);
        check("mid_rst_status", {busy, overrun}, 2'b00);
        check("mid_rst_inport", in_portRTC, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) tick();
        check("mid_no_start", {busy, cs_n}, 2'b01);
        actRTC = 1'b0;
        tick();
        actRTC = 1'b1;
        repeat (3) tick();
        check("mid_restart", {busy, cs_n}, 2'b10);
        begin
            int k;
            k = 0;
            while (!done && k < 40) begin
                tick();
                k++;
            end
            check("mid_done_seen", done, 1'b1);
        end
        actRTC = 1'b0; writestrobe = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
